mc_control_fsm: RTL and testbench

Multi-cycle RV32I control unit. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the write-enables of the datapath's 32-bit enable registers (PC, IR, OldPC) plus the register-file write, memory write and all datapath mux selects. It sits directly upstream of those enable registers: its `o_PCWrite` and `o_IRWrite` outputs connect to their `i_wEnable` inputs.

---
 rtl/mc_ctrl_pkg.sv | 146 ++++++++++++++
 rtl/mc_alu_decoder.sv | 31 +++
 rtl/mc_control_fsm.sv | 100 ++++++++++
 tb/tb_mc_control_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_IMMEXT = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALUOp (control-to-ALU-decoder class)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Per-state control word; everything not named in a state stays 0
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SRCA_PC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMMEXT;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMMEXT;
        c.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = RES_ALUOUT;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMMEXT;
        c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = SRCA_A;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALUOP_SUB;
        c.result_src = RES_ALUOUT;
        c.branch     = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a  = SRCA_OLDPC;
        c.alu_src_b  = SRCB_FOUR;
        c.alu_op     = ALUOP_ADD;
        c.result_src = RES_ALUOUT;
        c.pc_update  = 1'b1;
      end
      S_TRAP: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct fields to an ALUControl code.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Only R-type (op5=1) with funct7b5 set selects subtract; I-type addi never does
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: state register, next-state logic,
// registered per-state control word, ImmSrc decode and ALU decode.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [6:0] i_Op,
  input  logic [2:0] i_Funct3,
  input  logic       i_Funct7b5,
  input  logic       i_Zero,
  output logic       o_PCWrite,
  output logic       o_IRWrite,
  output logic       o_RegWrite,
  output logic       o_MemWrite,
  output logic       o_AdrSrc,
  output logic [1:0] o_ResultSrc,
  output logic [1:0] o_ALUSrcA,
  output logic [1:0] o_ALUSrcB,
  output logic [2:0] o_ALUControl,
  output logic [1:0] o_ImmSrc,
  output logic       o_Illegal
);

  state_t state;
  state_t state_nx;
  ctrl_t  ctrl;

  // Next-state selection; i_Op is only consulted in DECODE and MEMADR
  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: begin
        case (i_Op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = S_EXECR;
          OP_I:         state_nx = S_EXECI;
          OP_BEQ:       state_nx = S_BEQ;
          OP_JAL:       state_nx = S_JAL;
          default:      state_nx = S_TRAP;
        endcase
      end
      S_MEMADR:   state_nx = i_Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: state_nx = S_FETCH;
      S_EXECR:    state_nx = S_ALUWB;
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BEQ:      state_nx = S_FETCH;
      S_JAL:      state_nx = S_ALUWB;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_FETCH;
    endcase
  end

  // State register with the control word registered alongside it, so the
  // outputs are glitch-free and drop to FETCH values the instant reset asserts
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state <= S_FETCH;
      ctrl  <= state_ctrl(S_FETCH);
    end else begin
      state <= state_nx;
      ctrl  <= state_ctrl(state_nx);
    end
  end

  // Immediate format depends on the opcode alone, independent of state
  always_comb begin
    o_ImmSrc = IMM_I;
    case (i_Op)
      OP_SW:   o_ImmSrc = IMM_S;
      OP_BEQ:  o_ImmSrc = IMM_B;
      OP_JAL:  o_ImmSrc = IMM_J;
      default: o_ImmSrc = IMM_I;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (i_Funct3),
    .funct7b5    (i_Funct7b5),
    .op5         (i_Op[5]),
    .alu_control (o_ALUControl)
  );

  // The branch term is the only combinational path from i_Zero to an enable
  assign o_PCWrite   = ctrl.pc_update | (ctrl.branch & i_Zero);
  assign o_IRWrite   = ctrl.ir_write;
  assign o_RegWrite  = ctrl.reg_write;
  assign o_MemWrite  = ctrl.mem_write;
  assign o_AdrSrc    = ctrl.adr_src;
  assign o_ResultSrc = ctrl.result_src;
  assign o_ALUSrcA   = ctrl.alu_src_a;
  assign o_ALUSrcB   = ctrl.alu_src_b;
  assign o_Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: randomized instruction stream
// against a per-instruction-class cycle model, plus reset and trap scenarios.
module tb_mc_control_fsm;

  logic       i_Clk;
  logic       i_Reset;
  logic [6:0] i_Op;
  logic [2:0] i_Funct3;
  logic       i_Funct7b5;
  logic       i_Zero;
  logic       o_PCWrite;
  logic       o_IRWrite;
  logic       o_RegWrite;
  logic       o_MemWrite;
  logic       o_AdrSrc;
  logic [1:0] o_ResultSrc;
  logic [1:0] o_ALUSrcA;
  logic [1:0] o_ALUSrcB;
  logic [2:0] o_ALUControl;
  logic [1:0] o_ImmSrc;
  logic       o_Illegal;

  int tests_run = 0;
  int tests_failed = 0;

  // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 I-type, 4 beq, 5 jal
  logic [6:0] class_op [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                               7'b0010011, 7'b1100011, 7'b1101111};
  int         class_cpi [6] = '{5, 4, 4, 4, 3, 4};

  mc_control_fsm dut (
    .i_Clk        (i_Clk),
    .i_Reset      (i_Reset),
    .i_Op         (i_Op),
    .i_Funct3     (i_Funct3),
    .i_Funct7b5   (i_Funct7b5),
    .i_Zero       (i_Zero),
    .o_PCWrite    (o_PCWrite),
    .o_IRWrite    (o_IRWrite),
    .o_RegWrite   (o_RegWrite),
    .o_MemWrite   (o_MemWrite),
    .o_AdrSrc     (o_AdrSrc),
    .o_ResultSrc  (o_ResultSrc),
    .o_ALUSrcA    (o_ALUSrcA),
    .o_ALUSrcB    (o_ALUSrcB),
    .o_ALUControl (o_ALUControl),
    .o_ImmSrc     (o_ImmSrc),
    .o_Illegal    (o_Illegal)
  );

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Output bundle:
  // {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, SrcA, SrcB, ALUControl, ImmSrc, Illegal}
  function automatic logic [16:0] observed();
    return {o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_AdrSrc, o_ResultSrc,
            o_ALUSrcA, o_ALUSrcB, o_ALUControl, o_ImmSrc, o_Illegal};
  endfunction

  function automatic logic [2:0] funct_alu(input int cls, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (cls == 2 && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = fetch) of an instruction of class cls
  function automatic logic [16:0] model(input int cls, input int k, input logic zero,
                                        input logic [2:0] f3, input logic f7);
    logic       pcw, irw, rw, mw, adr;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu;
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0;
    res = 0; a = 0; b = 0; alu = 0;
    imm = (cls == 1) ? 2'b01 : (cls == 4) ? 2'b10 : (cls == 5) ? 2'b11 : 2'b00;
    if (k == 0) begin
      pcw = 1; irw = 1; b = 2'b10; res = 2'b10;
    end else if (k == 1) begin
      a = 2'b01; b = 2'b01;
    end else if (k == 2) begin
      case (cls)
        0, 1: begin a = 2'b10; b = 2'b01; end
        2:    begin a = 2'b10; b = 2'b00; alu = funct_alu(cls, f3, f7); end
        3:    begin a = 2'b10; b = 2'b01; alu = funct_alu(cls, f3, f7); end
        4:    begin a = 2'b10; b = 2'b00; alu = 3'b001; pcw = zero; end
        default: begin a = 2'b01; b = 2'b10; pcw = 1; end
      endcase
    end else if (k == 3) begin
      if (cls == 0) adr = 1;
      else if (cls == 1) begin adr = 1; mw = 1; end
      else rw = 1;
    end else if (k == 4) begin
      rw = 1; res = 2'b01;
    end
    return {pcw, irw, rw, mw, adr, res, a, b, alu, imm, 1'b0};
  endfunction

  // Drives one full instruction starting in FETCH (just after a falling edge)
  // and compares every cycle; zmode 0/1 forces i_Zero, 2 randomizes it
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7, input int zmode);
    logic [16:0] exp_v;
    logic [16:0] got;
    i_Op = class_op[cls];
    i_Funct3 = f3;
    i_Funct7b5 = f7;
    for (int k = 0; k < class_cpi[cls]; k++) begin
      i_Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      exp_v = model(cls, k, i_Zero, f3, f7);
      got = observed();
      tests_run++;
      if (got !== exp_v) begin
        tests_failed++;
        $display("FAIL instr cls=%0d cycle=%0d: got %b, expected %b", cls, k, got, exp_v);
      end
      @(negedge i_Clk);
    end
  endtask

  task automatic test_reset();
    logic [16:0] fetch_v;
    i_Op = 7'b0000011; i_Funct3 = 0; i_Funct7b5 = 0; i_Zero = 0;
    i_Reset = 1'b1;
    #1 i_Reset = 1'b0;
    repeat (3) @(negedge i_Clk);
    #1;
    fetch_v = model(0, 0, 1'b0, 3'd0, 1'b0);
    tests_run++;
    if (observed() !== fetch_v) begin
      tests_failed++;
      $display("FAIL reset outputs: got %b, expected %b", observed(), fetch_v);
    end
    i_Reset = 1'b1;
    // First fetch after release: the lw must take exactly five cycles
    run_instr(0, 3'd0, 1'b0, 2);
  endtask

  task automatic test_alu_decode();
    run_instr(2, 3'd0, 1'b1, 2);  // sub
    run_instr(2, 3'd0, 1'b0, 2);  // add
    run_instr(2, 3'd7, 1'b0, 2);  // and
    run_instr(2, 3'd6, 1'b1, 2);  // or
    run_instr(2, 3'd2, 1'b0, 2);  // slt
    run_instr(3, 3'd0, 1'b1, 2);  // addi ignores funct7b5
    run_instr(3, 3'd7, 1'b1, 2);  // andi
  endtask

  task automatic test_mem_branch_jump();
    run_instr(1, 3'd2, 1'b0, 2);  // sw
    run_instr(0, 3'd2, 1'b0, 2);  // lw
    run_instr(4, 3'd0, 1'b0, 1);  // beq taken
    run_instr(4, 3'd0, 1'b0, 0);  // beq not taken
    run_instr(5, 3'd0, 1'b0, 2);  // jal
  endtask

  task automatic test_back_to_back();
    int cls;
    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 5);
      run_instr(cls, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2);
    end
  endtask

  task automatic test_trap();
    logic [16:0] exp_v;
    i_Op = 7'b0000000; i_Funct3 = 3'($urandom_range(0, 7)); i_Funct7b5 = 1'b1;
    // FETCH then DECODE, then TRAP forever
    repeat (2) @(negedge i_Clk);
    for (int k = 0; k < 12; k++) begin
      i_Zero = 1'($urandom_range(0, 1));
      #1;
      exp_v = 17'b1;  // only Illegal, all selects 0, ImmSrc I, ALU add
      tests_run++;
      if (observed() !== exp_v) begin
        tests_failed++;
        $display("FAIL trap cycle=%0d: got %b, expected %b", k, observed(), exp_v);
      end
      @(negedge i_Clk);
    end
    i_Op = 7'b0000011;
    i_Reset = 1'b0;
    #1;
    exp_v = model(0, 0, i_Zero, i_Funct3, i_Funct7b5);
    tests_run++;
    if (observed() !== exp_v) begin
      tests_failed++;
      $display("FAIL reset in trap: got %b, expected %b", observed(), exp_v);
    end
    @(negedge i_Clk);
    i_Reset = 1'b1;
    run_instr(3, 3'd6, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    logic [16:0] exp_v;
    i_Op = 7'b0000011; i_Funct3 = 3'd2; i_Funct7b5 = 1'b0; i_Zero = 1'b0;
    // Advance to MEMWB (fifth cycle of lw)
    repeat (4) @(negedge i_Clk);
    #1;
    tests_run++;
    if (o_RegWrite !== 1'b1) begin
      tests_failed++;
      $display("FAIL memwb regwrite: got %b, expected 1", o_RegWrite);
    end
    i_Reset = 1'b0;
    #1;
    exp_v = model(0, 0, 1'b0, 3'd2, 1'b0);
    tests_run++;
    if (observed() !== exp_v) begin
      tests_failed++;
      $display("FAIL reset in memwb: got %b, expected %b", observed(), exp_v);
    end
    // Hold reset across a clock edge; no write may appear
    @(posedge i_Clk);
    #1;
    tests_run++;
    if ({o_RegWrite, o_MemWrite} !== 2'b00) begin
      tests_failed++;
      $display("FAIL writes during reset: got %b, expected 00", {o_RegWrite, o_MemWrite});
    end
    @(negedge i_Clk);
    i_Reset = 1'b1;
    run_instr(1, 3'd2, 1'b0, 2);
    run_instr(5, 3'd0, 1'b0, 2);
  endtask

  initial begin
    test_reset();
    test_alu_decode();
    test_mem_branch_jump();
    test_back_to_back();
    test_trap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
